byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer_if.sv | 22 ++
 rtl/byte_packer.sv | 85 ++++++++
 tb/tb_byte_packer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_packer_if.sv
// Byte stream in, 128-bit block out, plus fill/timeout status.
// slave is the packer side, master is the byte source / block consumer side.
interface byte_packer_if;
   logic [7:0]   s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [127:0] block_out;
   logic         block_valid;
   logic         block_ready;
   logic [4:0]   fill_level;
   logic         timeout_err;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, block_ready,
      output s_axis_tready, block_out, block_valid, fill_level, timeout_err
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, block_ready,
      input  s_axis_tready, block_out, block_valid, fill_level, timeout_err
   );
endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream (first byte most significant) into 16-byte blocks.
// A completed block is held until the consumer takes it; a partial block
// idle for TIMEOUT_CYCLES cycles is dropped (0 disables the timeout).
module byte_packer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic          clk,
   input  logic          reset,
   byte_packer_if.slave  bus
);
   typedef enum logic {COLLECT, HOLD} state_t;

   localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

   state_t         state;
   // Only the 15 most recent bytes need storing; the 16th goes straight to block_out.
   logic [119:0]   shift_reg;
   logic [31:0]    idle_cnt;
   logic           hs;
   logic           timeout_hit;

   assign hs = bus.s_axis_tvalid & bus.s_axis_tready;

   // Threshold is hit on the edge that would bring the idle count to TIMEOUT_CYCLES;
   // a handshake on that same edge takes priority.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == COLLECT) &&
                        (bus.fill_level != 5'd0) && !hs &&
                        (idle_cnt == TO_LIMIT - 32'd1);

   // Collect/hold state machine with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= COLLECT;
         shift_reg         <= '0;
         idle_cnt          <= '0;
         bus.s_axis_tready <= 1'b0;
         bus.block_out     <= '0;
         bus.block_valid   <= 1'b0;
         bus.fill_level    <= '0;
         bus.timeout_err   <= 1'b0;
      end else begin
         bus.timeout_err <= 1'b0;
         case (state)
            COLLECT: begin
               bus.s_axis_tready <= 1'b1;
               if (hs) begin
                  idle_cnt <= '0;
                  if (bus.fill_level == 5'd15) begin
                     bus.block_out     <= {shift_reg, bus.s_axis_tdata};
                     bus.block_valid   <= 1'b1;
                     bus.s_axis_tready <= 1'b0;
                     bus.fill_level    <= 5'd16;
                     shift_reg         <= '0;
                     state             <= HOLD;
                  end else begin
                     shift_reg      <= {shift_reg[111:0], bus.s_axis_tdata};
                     bus.fill_level <= bus.fill_level + 5'd1;
                  end
               end else if (timeout_hit) begin
                  shift_reg       <= '0;
                  bus.fill_level  <= '0;
                  idle_cnt        <= '0;
                  bus.timeout_err <= 1'b1;
               end else if (bus.fill_level != 5'd0) begin
                  idle_cnt <= idle_cnt + 32'd1;
               end else begin
                  idle_cnt <= '0;
               end
            end
            HOLD: begin
               idle_cnt          <= '0;
               bus.s_axis_tready <= 1'b0;
               // Release edge accepts no byte; tready only rises for the next edge.
               if (bus.block_ready) begin
                  bus.block_valid   <= 1'b0;
                  bus.fill_level    <= '0;
                  bus.s_axis_tready <= 1'b1;
                  state             <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer with a short timeout (8 cycles).
module tb_byte_packer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   to_cnt = 0;

   always #5 clk = ~clk;

   byte_packer_if bus();

   byte_packer #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Count timeout pulses, one per cycle high.
   always @(negedge clk) if (bus.timeout_err === 1'b1) to_cnt++;

   // Safety net in case something stalls outside a bounded wait.
   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a byte and return #1 after the edge that accepted it; tvalid stays high.
   task automatic push(input logic [7:0] b);
      int n;
      n = 0;
      bus.s_axis_tdata  = b;
      bus.s_axis_tvalid = 1'b1;
      while (bus.s_axis_tready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL push_wait tready=%b, required 1 within 50 cycles", bus.s_axis_tready);
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = 8'h00;
      bus.block_ready   = 1'b0;
      repeat (3) tick();
      tests++;
      if (bus.s_axis_tready !== 1'b0 || bus.block_valid !== 1'b0 || bus.block_out !== 128'h0 ||
          bus.fill_level !== 5'd0 || bus.timeout_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs tready=%b valid=%b out=%h fill=%0d err=%b, required all 0",
                  bus.s_axis_tready, bus.block_valid, bus.block_out, bus.fill_level, bus.timeout_err);
      end
      reset = 1'b0;
      tests++;
      if (bus.s_axis_tready !== 1'b0) begin
         fails++;
         $display("FAIL reset_release_pre tready=%b, required 0", bus.s_axis_tready);
      end
      tick();
      tests++;
      if (bus.s_axis_tready !== 1'b1) begin
         fails++;
         $display("FAIL reset_release_post tready=%b, required 1", bus.s_axis_tready);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp;
      exp = 128'h000102030405060708090A0B0C0D0E0F;
      bus.block_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         if (i < 15) begin
            tests++;
            if (bus.fill_level !== 5'(i + 1)) begin
               fails++;
               $display("FAIL b2b_fill byte %0d fill=%0d, required %0d", i, bus.fill_level, i + 1);
            end
         end
      end
      bus.s_axis_tvalid = 1'b0;
      tests++;
      if (bus.block_valid !== 1'b1 || bus.block_out !== exp || bus.fill_level !== 5'd16 ||
          bus.s_axis_tready !== 1'b0) begin
         fails++;
         $display("FAIL b2b_block valid=%b out=%h fill=%0d tready=%b, required 1 %h 16 0",
                  bus.block_valid, bus.block_out, bus.fill_level, bus.s_axis_tready, exp);
      end
      tick();
      tests++;
      if (bus.block_valid !== 1'b0 || bus.fill_level !== 5'd0 || bus.s_axis_tready !== 1'b1 ||
          bus.block_out !== exp) begin
         fails++;
         $display("FAIL b2b_release valid=%b fill=%0d tready=%b out=%h, required 0 0 1 %h",
                  bus.block_valid, bus.fill_level, bus.s_axis_tready, bus.block_out, exp);
      end
   endtask

   task automatic test_hold();
      logic [127:0] exp, exp2;
      logic ok;
      exp  = 128'h101112131415161718191A1B1C1D1E1F;
      exp2 = 128'h55565758595A5B5C5D5E5F6061626364;
      bus.block_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      bus.s_axis_tdata = 8'h55;
      ok = 1'b1;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) tick();
         if (bus.s_axis_tready !== 1'b0 || bus.fill_level !== 5'd16 ||
             bus.block_valid !== 1'b1 || bus.block_out !== exp) ok = 1'b0;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL hold_stable tready=%b fill=%0d valid=%b out=%h, required 0 16 1 %h",
                  bus.s_axis_tready, bus.fill_level, bus.block_valid, bus.block_out, exp);
      end
      bus.block_ready = 1'b1;
      tick();
      tests++;
      if (bus.block_valid !== 1'b0 || bus.fill_level !== 5'd0 || bus.s_axis_tready !== 1'b1) begin
         fails++;
         $display("FAIL hold_release valid=%b fill=%0d tready=%b, required 0 0 1",
                  bus.block_valid, bus.fill_level, bus.s_axis_tready);
      end
      tick();
      tests++;
      if (bus.fill_level !== 5'd1) begin
         fails++;
         $display("FAIL hold_pending_accept fill=%0d, required 1", bus.fill_level);
      end
      for (int i = 1; i < 16; i++) push(8'h55 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      tests++;
      if (bus.block_out !== exp2 || bus.block_valid !== 1'b1) begin
         fails++;
         $display("FAIL hold_next_block out=%h valid=%b, required %h 1", bus.block_out, bus.block_valid, exp2);
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [127:0] exp;
      logic ok;
      int base;
      exp  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
      base = to_cnt;
      bus.block_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      ok = 1'b1;
      repeat (7) begin
         tick();
         if (bus.timeout_err !== 1'b0 || bus.fill_level !== 5'd5) ok = 1'b0;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL timeout_early err=%b fill=%0d, required 0 5", bus.timeout_err, bus.fill_level);
      end
      tick();
      tests++;
      if (bus.timeout_err !== 1'b1 || bus.fill_level !== 5'd0) begin
         fails++;
         $display("FAIL timeout_fire err=%b fill=%0d, required 1 0", bus.timeout_err, bus.fill_level);
      end
      tick();
      tests++;
      if (bus.timeout_err !== 1'b0 || to_cnt - base !== 1) begin
         fails++;
         $display("FAIL timeout_once err=%b pulses=%0d, required 0 1", bus.timeout_err, to_cnt - base);
      end
      for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      tests++;
      if (bus.block_out !== exp || bus.block_valid !== 1'b1) begin
         fails++;
         $display("FAIL timeout_next_block out=%h valid=%b, required %h 1", bus.block_out, bus.block_valid, exp);
      end
      tick();
   endtask

   task automatic test_gap();
      logic [127:0] exp;
      int base;
      exp  = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
      base = to_cnt;
      for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      repeat (7) tick();
      // Next accept lands exactly on the threshold edge.
      for (int i = 5; i < 16; i++) push(8'hB0 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      tests++;
      if (bus.block_out !== exp || to_cnt != base) begin
         fails++;
         $display("FAIL gap_block out=%h pulses=%0d, required %h 0", bus.block_out, to_cnt - base, exp);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [127:0] exp;
      exp = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
      for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      #2 reset = 1'b1;
      #1;
      tests++;
      if (bus.fill_level !== 5'd0 || bus.s_axis_tready !== 1'b0 || bus.timeout_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid fill=%0d tready=%b err=%b, required 0 0 0",
                  bus.fill_level, bus.s_axis_tready, bus.timeout_err);
      end
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 3)) begin
            bus.s_axis_tvalid = 1'b0;
            tick();
         end
         push(8'hC0 + 8'(i));
      end
      bus.s_axis_tvalid = 1'b0;
      tests++;
      if (bus.block_out !== exp || bus.block_valid !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_block out=%h valid=%b, required %h 1", bus.block_out, bus.block_valid, exp);
      end
      tick();
      bus.block_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'hE0 + 8'(i));
      bus.s_axis_tvalid = 1'b0;
      #2 reset = 1'b1;
      #1;
      tests++;
      if (bus.block_valid !== 1'b0 || bus.block_out !== 128'h0 || bus.fill_level !== 5'd0 ||
          bus.timeout_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold valid=%b out=%h fill=%0d err=%b, required 0 0 0 0",
                  bus.block_valid, bus.block_out, bus.fill_level, bus.timeout_err);
      end
      tick();
      reset = 1'b0;
      tick();
      tests++;
      if (bus.s_axis_tready !== 1'b1 || bus.block_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold_after tready=%b valid=%b, required 1 0", bus.s_axis_tready, bus.block_valid);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_hold();
      test_timeout();
      test_gap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
